mem_port_router: RTL and testbench

MEM_PORT_ROUTER -- requirements
Module: mem_port_router

---
 rtl/femto_pkg.sv | 14 +
 rtl/mem_port_router_if.sv | 45 ++++
 rtl/mem_grant_arb.sv | 37 +++
 rtl/mem_port_router.sv | 91 +++++++++
 tb/tb_mem_port_router.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/femto_pkg.sv
// Shared types and defaults for the femto memory subsystem.
// owner_t names which requester owns the response slot one cycle after a grant.
package femto_pkg;

  localparam int XLEN_DEFAULT        = 32;
  localparam int MAX_D_BURST_DEFAULT = 3;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

endpackage

// File: rtl/mem_port_router_if.sv
// Fetch port, data port and unified memory command bundled for the router.
// Handshake: a requester holds *_req_valid and its payload until *_req_ready is
// seen high in the same cycle; that cycle is the grant, and the matching
// *_rsp_valid pulses for exactly one cycle on the following cycle.
interface mem_port_router_if import femto_pkg::*; #(
  parameter int XLEN = XLEN_DEFAULT
);

  logic              if_req_valid;
  logic [XLEN-1:0]   if_addr;
  logic              if_req_ready;
  logic              if_rsp_valid;
  logic [XLEN-1:0]   if_rsp_data;

  logic              d_req_valid;
  logic [XLEN-1:0]   d_addr;
  logic              d_we;
  logic [XLEN-1:0]   d_wdata;
  logic [XLEN/8-1:0] d_be;
  logic              d_req_ready;
  logic              d_rsp_valid;
  logic [XLEN-1:0]   d_rsp_data;

  logic              mem_req;
  logic [XLEN-1:0]   mem_addr;
  logic              mem_we;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN/8-1:0] mem_be;
  logic [XLEN-1:0]   mem_rdata;

  modport master (
    output if_req_valid, if_addr, d_req_valid, d_addr, d_we, d_wdata, d_be, mem_rdata,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    input  d_req_ready, d_rsp_valid, d_rsp_data,
    input  mem_req, mem_addr, mem_we, mem_wdata, mem_be
  );

  modport slave (
    input  if_req_valid, if_addr, d_req_valid, d_addr, d_we, d_wdata, d_be, mem_rdata,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    output d_req_ready, d_rsp_valid, d_rsp_data,
    output mem_req, mem_addr, mem_we, mem_wdata, mem_be
  );

endinterface

// File: rtl/mem_grant_arb.sv
// Grant arbiter: data wins by default, but after MAX_D_BURST consecutive data
// grants with a fetch waiting, the fetch gets the next slot.
module mem_grant_arb import femto_pkg::*; #(
  parameter int MAX_D_BURST = MAX_D_BURST_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic if_req_valid,
  input  logic d_req_valid,
  output logic grant_if,
  output logic grant_d
);

  localparam int CW = (MAX_D_BURST < 1) ? 1 : $clog2(MAX_D_BURST + 1);

  logic [CW-1:0] burst_cnt;
  logic          burst_full;

  assign burst_full = (burst_cnt == CW'(MAX_D_BURST));

  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (en) begin
      if (d_req_valid && !(burst_full && if_req_valid)) grant_d = 1'b1;
      else if (if_req_valid)                            grant_if = 1'b1;
    end
  end

  // Counts only data grants that actually held off a waiting fetch.
  always_ff @(posedge clk) begin
    if (rst || grant_if || !if_req_valid) burst_cnt <= '0;
    else if (grant_d && !burst_full)      burst_cnt <= burst_cnt + CW'(1);
  end

endmodule

// File: rtl/mem_port_router.sv
// Routes fetch and load/store requests onto one single-cycle memory port and
// steers the returning read data back to the requester that owned the slot.
module mem_port_router import femto_pkg::*; #(
  parameter int XLEN        = XLEN_DEFAULT,
  parameter int MAX_D_BURST = MAX_D_BURST_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_router_if.slave   bus,
  output owner_t             owner_dbg
);

  localparam logic [XLEN/8-1:0] BE_ALL = '1;

  logic   rst_q;
  logic   grant_en;
  logic   grant_if;
  logic   grant_d;
  owner_t owner;
  owner_t owner_nxt;
  logic   store_q;
  logic   store_nxt;
  logic   rsp_live;

  // Grants are held off during reset and for the cycle right after it.
  assign grant_en = !rst && !rst_q;

  mem_grant_arb #(.MAX_D_BURST(MAX_D_BURST)) u_arb (
    .clk          (clk),
    .rst          (rst),
    .en           (grant_en),
    .if_req_valid (bus.if_req_valid),
    .d_req_valid  (bus.d_req_valid),
    .grant_if     (grant_if),
    .grant_d      (grant_d)
  );

  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      owner   <= OWN_NONE;
      store_q <= 1'b0;
    end else begin
      owner   <= owner_nxt;
      store_q <= store_nxt;
    end
  end

  always_comb begin
    owner_nxt = OWN_NONE;
    store_nxt = 1'b0;
    if (grant_if) begin
      owner_nxt = OWN_IF;
    end else if (grant_d) begin
      owner_nxt = OWN_D;
      store_nxt = bus.d_we;
    end
  end

  always_comb begin
    bus.mem_req   = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    bus.mem_be    = '0;
    if (grant_if) begin
      bus.mem_req  = 1'b1;
      bus.mem_addr = bus.if_addr;
      bus.mem_be   = BE_ALL;
    end else if (grant_d) begin
      bus.mem_req   = 1'b1;
      bus.mem_addr  = bus.d_addr;
      bus.mem_we    = bus.d_we;
      bus.mem_wdata = bus.d_wdata;
      bus.mem_be    = bus.d_be;
    end
  end

  assign bus.if_req_ready = grant_if;
  assign bus.d_req_ready  = grant_d;

  // A response still in flight when reset arrives is dropped here.
  assign rsp_live         = !rst;
  assign bus.if_rsp_valid = rsp_live && (owner == OWN_IF);
  assign bus.if_rsp_data  = bus.if_rsp_valid ? bus.mem_rdata : '0;
  assign bus.d_rsp_valid  = rsp_live && (owner == OWN_D);
  assign bus.d_rsp_data   = (bus.d_rsp_valid && !store_q) ? bus.mem_rdata : '0;

  assign owner_dbg = owner;

endmodule

// File: tb/tb_mem_port_router.sv
// Directed bench for mem_port_router: reset, fetch, load, store, starvation
// guard, back-to-back ownership and reset with a response in flight.
module tb_mem_port_router;
  import femto_pkg::*;

  logic   clk;
  logic   rst;
  owner_t owner_dbg;
  int     checks;
  int     errors;

  mem_port_router_if #(.XLEN(32)) bus ();

  mem_port_router #(.XLEN(32), .MAX_D_BURST(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .owner_dbg (owner_dbg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.if_req_valid = 1'b0;
    bus.if_addr      = '0;
    bus.d_req_valid  = 1'b0;
    bus.d_addr       = '0;
    bus.d_we         = 1'b0;
    bus.d_wdata      = '0;
    bus.d_be         = '0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    idle();
    bus.mem_rdata = '0;

    // Reset with both requests pending: nothing is granted.
    tick();
    bus.if_req_valid = 1'b1;
    bus.if_addr      = 32'h0000_0040;
    bus.d_req_valid  = 1'b1;
    bus.d_addr       = 32'h0000_0080;
    #1;
    chk("rst_if_ready", bus.if_req_ready, 0);
    chk("rst_d_ready", bus.d_req_ready, 0);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    tick();
    chk("rst_owner", owner_dbg, OWN_NONE);
    chk("rst_if_rsp", bus.if_rsp_valid, 0);
    chk("rst_d_rsp", bus.d_rsp_valid, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_mem_req", bus.mem_req, 0);
    chk("post_rst_d_ready", bus.d_req_ready, 0);
    chk("post_rst_if_ready", bus.if_req_ready, 0);
    idle();
    tick();

    // Fetch only.
    bus.if_req_valid = 1'b1;
    bus.if_addr      = 32'h0000_0100;
    #1;
    chk("f_if_ready", bus.if_req_ready, 1);
    chk("f_d_ready", bus.d_req_ready, 0);
    chk("f_mem_req", bus.mem_req, 1);
    chk("f_mem_addr", bus.mem_addr, 32'h100);
    chk("f_mem_be", bus.mem_be, 4'hF);
    chk("f_mem_we", bus.mem_we, 0);
    chk("f_mem_wdata", bus.mem_wdata, 0);
    tick();
    idle();
    bus.mem_rdata = 32'h0050_0093;
    #1;
    chk("f_owner", owner_dbg, OWN_IF);
    chk("f_if_rsp_valid", bus.if_rsp_valid, 1);
    chk("f_if_rsp_data", bus.if_rsp_data, 32'h0050_0093);
    chk("f_d_rsp_valid", bus.d_rsp_valid, 0);
    chk("f_d_rsp_data", bus.d_rsp_data, 0);
    chk("idle_mem_req", bus.mem_req, 0);
    chk("idle_mem_addr", bus.mem_addr, 0);
    chk("idle_mem_be", bus.mem_be, 0);
    tick();
    chk("idle_if_rsp", bus.if_rsp_valid, 0);
    chk("idle_if_rsp_data", bus.if_rsp_data, 0);

    // Simultaneous fetch and load: data wins.
    bus.if_req_valid = 1'b1;
    bus.if_addr      = 32'h0000_0104;
    bus.d_req_valid  = 1'b1;
    bus.d_addr       = 32'h0000_0200;
    bus.d_be         = 4'hF;
    #1;
    chk("s_d_ready", bus.d_req_ready, 1);
    chk("s_if_ready", bus.if_req_ready, 0);
    chk("s_mem_addr", bus.mem_addr, 32'h200);
    chk("s_mem_we", bus.mem_we, 0);
    tick();
    idle();
    bus.mem_rdata = 32'hCAFE_F00D;
    #1;
    chk("s_d_rsp_valid", bus.d_rsp_valid, 1);
    chk("s_d_rsp_data", bus.d_rsp_data, 32'hCAFE_F00D);
    chk("s_if_rsp_valid", bus.if_rsp_valid, 0);
    chk("s_if_rsp_data", bus.if_rsp_data, 0);
    tick();

    // Starvation guard: three data grants, then the fetch, then data again.
    bus.if_req_valid = 1'b1;
    bus.if_addr      = 32'h0000_0180;
    bus.d_req_valid  = 1'b1;
    bus.d_addr       = 32'h0000_0400;
    bus.d_be         = 4'hF;
    #1;
    chk("b1_d_ready", bus.d_req_ready, 1);
    chk("b1_if_ready", bus.if_req_ready, 0);
    tick();
    bus.mem_rdata = 32'h0000_0011;
    #1;
    chk("b2_d_ready", bus.d_req_ready, 1);
    chk("b2_if_ready", bus.if_req_ready, 0);
    chk("b2_d_rsp_valid", bus.d_rsp_valid, 1);
    chk("b2_d_rsp_data", bus.d_rsp_data, 32'h11);
    tick();
    bus.mem_rdata = 32'h0000_0022;
    #1;
    chk("b3_d_ready", bus.d_req_ready, 1);
    chk("b3_if_ready", bus.if_req_ready, 0);
    tick();
    bus.mem_rdata = 32'h0000_0033;
    #1;
    chk("b4_if_ready", bus.if_req_ready, 1);
    chk("b4_d_ready", bus.d_req_ready, 0);
    chk("b4_mem_addr", bus.mem_addr, 32'h180);
    chk("b4_d_rsp_data", bus.d_rsp_data, 32'h33);
    tick();
    bus.mem_rdata = 32'h0000_0044;
    #1;
    chk("b5_d_ready", bus.d_req_ready, 1);
    chk("b5_if_ready", bus.if_req_ready, 0);
    chk("b5_if_rsp_valid", bus.if_rsp_valid, 1);
    chk("b5_if_rsp_data", bus.if_rsp_data, 32'h44);
    chk("b5_d_rsp_valid", bus.d_rsp_valid, 0);
    tick();
    idle();
    bus.mem_rdata = 32'h0000_0055;
    #1;
    chk("b6_d_rsp_valid", bus.d_rsp_valid, 1);
    chk("b6_d_rsp_data", bus.d_rsp_data, 32'h55);
    tick();

    // Store acknowledge carries zero data.
    bus.d_req_valid = 1'b1;
    bus.d_we        = 1'b1;
    bus.d_addr      = 32'h0000_0300;
    bus.d_wdata     = 32'hDEAD_BEEF;
    bus.d_be        = 4'h3;
    #1;
    chk("st_d_ready", bus.d_req_ready, 1);
    chk("st_mem_we", bus.mem_we, 1);
    chk("st_mem_be", bus.mem_be, 4'h3);
    chk("st_mem_addr", bus.mem_addr, 32'h300);
    chk("st_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    tick();
    idle();
    bus.mem_rdata = 32'hFFFF_FFFF;
    #1;
    chk("st_d_rsp_valid", bus.d_rsp_valid, 1);
    chk("st_d_rsp_data", bus.d_rsp_data, 0);
    tick();

    // Back-to-back: fetch at N, load at N+1.
    bus.if_req_valid = 1'b1;
    bus.if_addr      = 32'h0000_0104;
    #1;
    chk("bb_if_ready", bus.if_req_ready, 1);
    tick();
    idle();
    bus.d_req_valid = 1'b1;
    bus.d_addr      = 32'h0000_0204;
    bus.d_be        = 4'hF;
    bus.mem_rdata   = 32'h1111_2222;
    #1;
    chk("bb_d_ready", bus.d_req_ready, 1);
    chk("bb_n1_if_rsp", bus.if_rsp_valid, 1);
    chk("bb_n1_if_data", bus.if_rsp_data, 32'h1111_2222);
    chk("bb_n1_d_rsp", bus.d_rsp_valid, 0);
    tick();
    idle();
    bus.mem_rdata = 32'h3333_4444;
    #1;
    chk("bb_n2_d_rsp", bus.d_rsp_valid, 1);
    chk("bb_n2_d_data", bus.d_rsp_data, 32'h3333_4444);
    chk("bb_n2_if_rsp", bus.if_rsp_valid, 0);
    tick();

    // Reset while a load response is in flight.
    bus.d_req_valid = 1'b1;
    bus.d_addr      = 32'h0000_0208;
    bus.d_be        = 4'hF;
    #1;
    chk("rm_d_ready", bus.d_req_ready, 1);
    tick();
    rst              = 1'b1;
    bus.if_req_valid = 1'b1;
    bus.mem_rdata    = 32'h5555_6666;
    #1;
    chk("rm_d_rsp_valid", bus.d_rsp_valid, 0);
    chk("rm_d_rsp_data", bus.d_rsp_data, 0);
    chk("rm_d_ready", bus.d_req_ready, 0);
    chk("rm_if_ready", bus.if_req_ready, 0);
    chk("rm_mem_req", bus.mem_req, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("rm_owner", owner_dbg, OWN_NONE);
    chk("rm_post_d_rsp", bus.d_rsp_valid, 0);
    chk("rm_post_mem_req", bus.mem_req, 0);
    tick();
    chk("rm_resume_d_ready", bus.d_req_ready, 1);
    chk("rm_resume_mem_addr", bus.mem_addr, 32'h208);
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
